fadd_acc: RTL and testbench
===========================

Name: fadd_acc

Overview:
- Streaming single-precision accumulator directly downstream of the combinational `fadd` core; instantiates one `fadd` and consumes its `y`/`ovf` every cycle.
- Sums a packet of IEEE-754 binary32 operands arriving on a valid/ready stream.
- Emits the packet sum, a sticky overflow flag and an element count on a valid/ready output.
- Feeds reduction/dot-product logic that needs FP sums, not single additions.

Parameters:
CNT_W, 16, width of element counter; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand valid
in_ready  output  1  block accepts operand
in_data  input  32  binary32 operand
in_last  input  1  marks final operand of packet
out_valid  output  1  packet result valid
out_ready  input  1  consumer accepts result
out_sum  output  32  binary32 packet sum
out_ovf  output  1  sticky OR of fadd ovf over packet
out_count  output  CNT_W  operands in packet (saturating)

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=32'h0, ovf_s=0, cnt=0, out_valid=0; in_ready=1 after release.
- Beat accepted = in_valid & in_ready at rising clk.
- States:
  - IDLE: no packet open. Accepted beat loads acc=in_data directly (no add, so -0 and NaN payloads pass bit-exact), cnt=1, ovf_s=0. If in_last, go to DONE; else go to ACC.
  - ACC: fadd x1=acc, x2=in_data. Accepted beat: acc<=y, ovf_s<=ovf_s|ovf, cnt<=sat(cnt+1). If in_last, go to DONE.
  - DONE: out_valid=1, in_ready=0. out_sum=acc, out_ovf=ovf_s, out_count=cnt held stable until out_ready=1. On the handshake go to IDLE and clear acc, ovf_s, cnt; out_valid drops next cycle.
- in_ready = (state!=DONE), combinational from state only, no path from in_valid.
- Throughput: one operand per cycle while in IDLE/ACC.
- Latency: last beat accepted at edge t, so out_valid=1 from t until the handshake. Minimum one idle in_ready=0 cycle between packets.
- fadd operands are driven only from registered acc and in_data. The y of an unaccepted cycle is ignored.
- Rounding, NaN, inf and ovf semantics are exactly those of `fadd`. No re-rounding, no exception handling added.
- Counter saturates at all-ones and never wraps. Accumulation continues after saturation.
- in_valid=0 in ACC: acc and cnt hold indefinitely.
- rst asserted mid-packet or in DONE: everything returns to reset values immediately. The partial packet is discarded, no out_valid pulse.
- in_data and in_last are ignored when not accepted.

Optional Feature:
- Macro FADD_ACC_OVF_HALT_EN.
- Defined:
  - First beat whose fadd ovf=1 still updates acc with y and sets ovf_s.
  - Later beats of that packet are accepted (in_ready stays 1) and counted, but acc is frozen.
  - out_sum is the value at the first overflow.
- Undefined:
  - Accumulation continues through overflow.
  - ovf_s is sticky only; acc follows fadd y.

Test Plan:
- Packet {0x3F800000, 0x40000000, 0x40400000} (1,2,3) back-to-back, last on third -> out_valid one cycle after third accept; out_sum=0x40C00000, out_ovf=0, out_count=3.
- Single-beat packet 0x80000000 (-0) with in_last -> out_sum=0x80000000 (bypass, not +0), out_count=1; in_ready=0 while out_valid=1.
- Packet {0x7F7FFFFF, 0x7F7FFFFF} -> out_ovf=1, out_sum = fadd(0x7F7FFFFF, 0x7F7FFFFF) result (compare against `$shortrealtobits` of shortreal sum). With FADD_ACC_OVF_HALT_EN, a third beat 0xFF7FFFFF leaves out_sum unchanged and gives count=3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum/out_ovf/out_count stable, in_ready=0 throughout. Raise out_ready -> out_valid low next cycle, next packet's first beat accepted that cycle.
- Gaps: in_valid toggling 1,0,0,1,0,1(last) with 1.0 each -> out_sum=0x40400000, out_count=3.
- rst pulsed asynchronously between edges mid-packet after 2 beats -> outputs at reset values before next edge. A following packet {0x40A00000} (5.0) gives out_sum=0x40A00000, out_count=1.

Source files
------------

// File: rtl/fadd_acc.sv
// Streaming binary32 packet accumulator built around the combinational fadd adder (also in this file).
// Optional FADD_ACC_OVF_HALT_EN: freeze the running sum at the first overflowing add of a packet.

module fadd (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  logic [31:0] big, sml;
  logic [7:0]  eb_e, es_e, d;
  logic [26:0] mb, ms, ms_sh, lost;
  logic [27:0] sum;
  logic [9:0]  e;
  logic [24:0] mr;
  logic        sub, rnd, x1_nan, x2_nan, x1_inf, x2_inf;

  always_comb begin
    y     = 32'h0;
    ovf   = 1'b0;
    lost  = 27'd0;
    ms_sh = 27'd0;
    big   = x1;
    sml   = x2;
    if (x2[30:0] > x1[30:0]) begin
      big = x2;
      sml = x1;
    end
    sub  = big[31] ^ sml[31];
    eb_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb   = {(big[30:23] != 8'd0), big[22:0], 3'b000};
    ms   = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
    d    = eb_e - es_e;
    // Align the smaller operand; shifted-out bits collapse into the sticky LSB.
    if (d > 8'd26) begin
      ms_sh = {26'd0, |ms};
    end else begin
      lost  = ms & ((27'd1 << d) - 27'd1);
      ms_sh = (ms >> d) | {26'd0, |lost};
    end
    sum = sub ? ({1'b0, mb} - {1'b0, ms_sh}) : ({1'b0, mb} + {1'b0, ms_sh});
    e   = {2'b00, eb_e};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26] && e > 10'd1) begin
        sum = sum << 1;
        e   = e - 10'd1;
      end
    end
    // Round to nearest, ties to even, on guard/round/sticky.
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'd1;
    end
    x1_nan = (&x1[30:23]) & (|x1[22:0]);
    x2_nan = (&x2[30:23]) & (|x2[22:0]);
    x1_inf = (&x1[30:23]) & ~(|x1[22:0]);
    x2_inf = (&x2[30:23]) & ~(|x2[22:0]);
    if (x1_nan | x2_nan | (x1_inf & x2_inf & (x1[31] ^ x2[31]))) begin
      y = 32'h7FC00000;
    end else if (x1_inf) begin
      y = x1;
    end else if (x2_inf) begin
      y = x2;
    end else if (sum == 28'd0) begin
      y = {~sub & big[31], 31'd0};
    end else if (e >= 10'd255) begin
      y   = {big[31], 8'hFF, 23'd0};
      ovf = 1'b1;
    end else begin
      y = {big[31], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
    end
  end
endmodule

// Stream contract: a beat moves on any rising edge where valid & ready are both high;
// ready never depends on valid, and a presented result is held stable until taken.
module fadd_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [31:0]        acc, y;
  logic               ovf, ovf_s, accept;
  logic [CNT_W-1:0]   cnt;

  fadd u_fadd (
    .x1  (acc),
    .x2  (in_data),
    .y   (y),
    .ovf (ovf)
  );

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign out_sum   = acc;
  assign out_ovf   = ovf_s;
  assign out_count = cnt;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACC: if (accept) state_nx = in_last ? DONE : ACC;
      DONE:      if (out_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 32'h0;
      ovf_s <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          // First operand loads directly so -0 and NaN payloads survive bit-exact.
          acc   <= in_data;
          cnt   <= CNT_W'(1);
          ovf_s <= 1'b0;
        end
        ACC: if (accept) begin
`ifdef FADD_ACC_OVF_HALT_EN
          if (!ovf_s) acc <= y;
`else
          acc <= y;
`endif
          ovf_s <= ovf_s | ovf;
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
        end
        DONE: if (out_ready) begin
          acc   <= 32'h0;
          ovf_s <= 1'b0;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fadd_acc.sv
// Directed bench for fadd_acc: hand-computed binary32 packet sums, counts and flags.
// Counter width is reduced to 2 bits so saturation is reachable with short packets.

module tb_fadd_acc;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [31:0]      in_data;
  logic             out_valid, out_ready, out_ovf;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic [1:0]       dbg_state;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  fadd_acc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at a falling edge; junk on data/last checks they are ignored.
  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must already be presented at the falling edge after the last beat.
  task automatic get_result(input string tag, input logic ovf, input int cnt);
    logic [31:0] es;
    es = exp_q.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    check({tag, "_sum"}, out_sum, es);
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", out_sum, 32'h0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    // 1 + 2 + 3 back-to-back
    exp_q.push_back(32'h40C00000);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    get_result("p123", 1'b0, 3);

    // Single -0 passes untouched
    exp_q.push_back(32'h80000000);
    send(32'h80000000, 1'b1);
    get_result("negzero", 1'b0, 1);

    // Single NaN payload passes untouched
    exp_q.push_back(32'h7FC12345);
    send(32'h7FC12345, 1'b1);
    get_result("nan_pass", 1'b0, 1);

    // Exact cancellation gives +0
    exp_q.push_back(32'h00000000);
    send(32'h3F800000, 1'b0);
    send(32'hBF800000, 1'b1);
    get_result("cancel", 1'b0, 2);

    // 1.5 + 0.25 - 0.75 = 1.0
    exp_q.push_back(32'h3F800000);
    send(32'h3FC00000, 1'b0);
    send(32'h3E800000, 1'b0);
    send(32'hBF400000, 1'b1);
    get_result("mixed", 1'b0, 3);

    // FLT_MAX + FLT_MAX rounds to +inf with overflow
    exp_q.push_back(32'h7F800000);
    send(32'h7F7FFFFF, 1'b0);
    send(32'h7F7FFFFF, 1'b1);
    get_result("ovf2", 1'b1, 2);

    // Adding -inf after overflow: NaN normally, frozen at +inf when halting
`ifdef FADD_ACC_OVF_HALT_EN
    exp_q.push_back(32'h7F800000);
`else
    exp_q.push_back(32'h7FC00000);
`endif
    send(32'h7F7FFFFF, 1'b0);
    send(32'h7F7FFFFF, 1'b0);
    send(32'hFF800000, 1'b1);
    get_result("ovf3", 1'b1, 3);

    // Five ones: count saturates at 3, sum keeps going to 5.0
    exp_q.push_back(32'h40A00000);
    for (int i = 0; i < 5; i++) send(32'h3F800000, (i == 4));
    get_result("sat", 1'b0, 3);

    // Backpressure: 2.5 + 0.5 held for five cycles
    exp_q.push_back(32'h40400000);
    send(32'h40200000, 1'b0);
    send(32'h3F000000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", out_sum, 32'h40400000);
      check("bp_count", 32'(out_count), 32'd2);
      check("bp_ready", 32'(in_ready), 32'd0);
      idle(1);
    end
    get_result("bp", 1'b0, 2);

    // Gapped stream of ones
    exp_q.push_back(32'h40400000);
    send(32'h3F800000, 1'b0);
    idle(2);
    send(32'h3F800000, 1'b0);
    idle(1);
    send(32'h3F800000, 1'b1);
    get_result("gaps", 1'b0, 3);

    // Asynchronous reset mid-packet discards the partial sum
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", out_sum, 32'h0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'h40A00000);
    send(32'h40A00000, 1'b1);
    get_result("after_rst", 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
